seq_delay_matcher: RTL

//  Runtime-programmable hardware matcher for x ##d1 y[*min:max] ##d2 z, clocked on the global clock.

---
 rtl/seq_delay_matcher.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_delay_matcher.sv
// seq_delay_matcher: runtime-programmable x ##d1 y[*min:max] ##d2 z matcher; define SEQ_MATCH_STATS_EN for match/fail counters
module seq_delay_matcher #(
    parameter int DLY_W = 3,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_load,
    input  logic [DLY_W-1:0] cfg_delay1,
    input  logic [DLY_W-1:0] cfg_delay2,
    input  logic [REP_W-1:0] cfg_min,
    input  logic [REP_W-1:0] cfg_max,
    input  logic             enable,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             busy,
    output logic             match,
    output logic             fail,
    output logic             cfg_err,
    output logic [1:0]       state
`ifdef SEQ_MATCH_STATS_EN
    ,
    output logic [15:0]      match_cnt,
    output logic [15:0]      fail_cnt
`endif
);
    localparam int PW = (1 << DLY_W) - 1;
    typedef enum logic [1:0] {IDLE = 2'd0, DLY1 = 2'd1, REP = 2'd2, DRAIN = 2'd3} state_e;
    state_e           state_q;
    logic [DLY_W-1:0] cnt_q, d1_q, d2_q;
    logic [REP_W-1:0] rep_q, min_q, max_q, rep_d;
    logic [PW-1:0]    pend_q, pend_d;
    logic             busy_q, match_q, fail_q, cfg_err_q;
    logic             hit, rep_fail, drain_fail, to_drain, win, start, load, cfg_bad;
    // decide this cycle's outcome: z hit on a due slot, repetition shortfall, or exhausted drain window
    always_comb begin
        hit        = (state_q == REP || state_q == DRAIN) && pend_q[0] && z;
        rep_d      = rep_q + REP_W'(1);
        win        = state_q == REP && y && rep_d >= min_q && rep_d <= max_q;
        pend_d     = (pend_q >> 1) | (win ? PW'(1) << (d2_q - DLY_W'(1)) : '0);
        rep_fail   = state_q == REP && !y && rep_q < min_q;
        to_drain   = state_q == REP && (y ? rep_d == max_q : rep_q >= min_q);
        drain_fail = state_q == DRAIN && (pend_q >> 1) == '0;
        start      = state_q == IDLE && enable && x && !cfg_err_q && !match_q && !fail_q && !cfg_load;
        load       = cfg_load && !busy_q;
        cfg_bad    = cfg_delay1 == '0 || cfg_delay2 == '0 || cfg_min == '0 || cfg_max < cfg_min;
    end
    // single attempt sequencer with shadow config and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rep_q     <= '0;
            pend_q    <= '0;
            d1_q      <= DLY_W'(1);
            d2_q      <= DLY_W'(1);
            min_q     <= REP_W'(1);
            max_q     <= REP_W'(1);
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b0;
            match_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            match_q <= hit;
            fail_q  <= !hit && (rep_fail || drain_fail);
            if (load) begin
                d1_q      <= cfg_delay1;
                d2_q      <= cfg_delay2;
                min_q     <= cfg_min;
                max_q     <= cfg_max;
                cfg_err_q <= cfg_bad;
            end
            case (state_q)
                IDLE: if (start) begin
                    state_q <= d1_q == DLY_W'(1) ? REP : DLY1;
                    cnt_q   <= d1_q - DLY_W'(1);
                    rep_q   <= '0;
                    pend_q  <= '0;
                    busy_q  <= 1'b1;
                end
                DLY1: begin
                    cnt_q <= cnt_q - DLY_W'(1);
                    if (cnt_q == DLY_W'(1)) state_q <= REP;
                end
                default: if (hit || rep_fail || drain_fail) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    pend_q  <= '0;
                end else begin
                    pend_q <= pend_d;
                    if (state_q == REP && y) rep_q <= rep_d;
                    if (to_drain) state_q <= DRAIN;
                end
            endcase
        end
    end
`ifdef SEQ_MATCH_STATS_EN
    logic [15:0] match_cnt_q, fail_cnt_q;
    // saturating outcome counters, stepped while the corresponding pulse is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            if (match_q && match_cnt_q != 16'hFFFF) match_cnt_q <= match_cnt_q + 16'd1;
            if (fail_q && fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
        end
    end
    assign match_cnt = match_cnt_q;
    assign fail_cnt  = fail_cnt_q;
`endif
    assign busy    = busy_q;
    assign match   = match_q;
    assign fail    = fail_q;
    assign cfg_err = cfg_err_q;
    assign state   = state_q;
endmodule
